// File: rtl/riscv_pkg.sv
// Shared RV32I constants: opcodes, immediate formats and the opcode-to-format map
// used by the decode stage.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
      case (opcode)
         OP_I, OP_LOAD, OP_JALR: return IMM_I;
         OP_STORE:               return IMM_S;
         OP_BRANCH:              return IMM_B;
         OP_LUI, OP_AUIPC:       return IMM_U;
         OP_JAL:                 return IMM_J;
         default:                return IMM_NONE;
      endcase
   endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// IF/ID, register-file, writeback and ID/EX signals of the decode stage.
// master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if #(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int RA_W = riscv_pkg::RA_W
);
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            id_stall;
   logic [RA_W-1:0] rf_a1;
   logic [RA_W-1:0] rf_a2;
   logic [XLEN-1:0] rf_rd1;
   logic [XLEN-1:0] rf_rd2;
   logic            wb_we;
   logic [RA_W-1:0] wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_ready;
   logic            ex_flush;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [RA_W-1:0] ex_rs1;
   logic [RA_W-1:0] ex_rs2;
   logic [RA_W-1:0] ex_rd;
   logic [6:0]      ex_opcode;
   logic [2:0]      ex_funct3;
   logic            ex_funct7b5;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic            ex_reg_write;

   modport master (
      output if_valid, if_instr, if_pc, rf_rd1, rf_rd2, wb_we, wb_rd, wb_data,
             ex_ready, ex_flush,
      input  id_stall, rf_a1, rf_a2, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
             ex_mem_read, ex_mem_write, ex_reg_write
   );

   modport slave (
      input  if_valid, if_instr, if_pc, rf_rd1, rf_rd2, wb_we, wb_rd, wb_data,
             ex_ready, ex_flush,
      output id_stall, rf_a1, rf_a2, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
             ex_mem_read, ex_mem_write, ex_reg_write
   );
endinterface

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational RV32I immediate generator; R-type and unknown opcodes yield 0.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] imm
);
   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_type_of(instr[6:0]))
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX register. ID_WB_BYPASS_EN selects same-cycle
// writeback forwarding; without it a WB/read collision costs one bubble instead.
module id_ex_stage #(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int RA_W = riscv_pkg::RA_W
) (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);
   import riscv_pkg::*;

   logic [6:0]      opcode;
   logic [RA_W-1:0] rd;
   logic [XLEN-1:0] imm;
   logic            is_u_or_j;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic            haz;
   logic            load_en;

   logic [RA_W-1:0] src_idx  [2];
   logic [XLEN-1:0] rf_rd    [2];
   logic [XLEN-1:0] src_data [2];
   logic            uses     [2];
   logic            load_hit [2];
   logic            wb_hit   [2];

   logic            ex_valid_reg;
   logic [XLEN-1:0] ex_pc_reg;
   logic [XLEN-1:0] ex_rs1_data_reg;
   logic [XLEN-1:0] ex_rs2_data_reg;
   logic [XLEN-1:0] ex_imm_reg;
   logic [RA_W-1:0] ex_rs1_reg;
   logic [RA_W-1:0] ex_rs2_reg;
   logic [RA_W-1:0] ex_rd_reg;
   logic [6:0]      ex_opcode_reg;
   logic [2:0]      ex_funct3_reg;
   logic            ex_funct7b5_reg;
   logic            ex_mem_read_reg;
   logic            ex_mem_write_reg;
   logic            ex_reg_write_reg;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (bus.if_instr),
      .imm   (imm)
   );

   assign opcode     = bus.if_instr[6:0];
   assign rd         = bus.if_instr[11:7];
   assign src_idx[0] = bus.if_instr[19:15];
   assign src_idx[1] = bus.if_instr[24:20];
   assign rf_rd[0]   = bus.rf_rd1;
   assign rf_rd[1]   = bus.rf_rd2;
   assign bus.rf_a1  = src_idx[0];
   assign bus.rf_a2  = src_idx[1];

   assign is_u_or_j = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL);
   assign uses[0]   = !is_u_or_j;
   assign uses[1]   = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   assign mem_read  = (opcode == OP_LOAD);
   assign mem_write = (opcode == OP_STORE);
   assign reg_write = (rd != '0) &&
                      ((opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                       (opcode == OP_JALR) || is_u_or_j);

   // Per-source operand selection and hazard matching.
   for (genvar gi = 0; gi < 2; gi++) begin : g_src
`ifdef ID_WB_BYPASS_EN
      assign src_data[gi] = (src_idx[gi] == '0) ? '0 :
                            (bus.wb_we && (bus.wb_rd == src_idx[gi])) ? bus.wb_data :
                            rf_rd[gi];
      assign wb_hit[gi]   = 1'b0;
`else
      assign src_data[gi] = (src_idx[gi] == '0) ? '0 : rf_rd[gi];
      // The register file returns the old value while it is being written.
      assign wb_hit[gi]   = uses[gi] && bus.wb_we && (bus.wb_rd != '0) &&
                            (bus.wb_rd == src_idx[gi]);
`endif
      assign load_hit[gi] = uses[gi] && (ex_rd_reg == src_idx[gi]);
   end

`ifndef ID_WB_BYPASS_EN
   logic unused_wb_data;
   assign unused_wb_data = ^bus.wb_data;
`endif

   assign haz = bus.if_valid &&
                ((ex_valid_reg && ex_mem_read_reg && (ex_rd_reg != '0) &&
                  (load_hit[0] || load_hit[1])) ||
                 wb_hit[0] || wb_hit[1]);

   assign load_en      = !bus.ex_flush && !haz;
   assign bus.id_stall = !rst && (!bus.ex_ready || (haz && !bus.ex_flush));

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_reg     <= 1'b0;
         ex_pc_reg        <= '0;
         ex_rs1_data_reg  <= '0;
         ex_rs2_data_reg  <= '0;
         ex_imm_reg       <= '0;
         ex_rs1_reg       <= '0;
         ex_rs2_reg       <= '0;
         ex_rd_reg        <= '0;
         ex_opcode_reg    <= '0;
         ex_funct3_reg    <= '0;
         ex_funct7b5_reg  <= 1'b0;
         ex_mem_read_reg  <= 1'b0;
         ex_mem_write_reg <= 1'b0;
         ex_reg_write_reg <= 1'b0;
      end else if (bus.ex_ready) begin
         // Data fields load unconditionally; a bubble is defined by valid and controls.
         ex_pc_reg        <= bus.if_pc;
         ex_rs1_data_reg  <= src_data[0];
         ex_rs2_data_reg  <= src_data[1];
         ex_imm_reg       <= imm;
         ex_rs1_reg       <= src_idx[0];
         ex_rs2_reg       <= src_idx[1];
         ex_rd_reg        <= rd;
         ex_opcode_reg    <= opcode;
         ex_funct3_reg    <= bus.if_instr[14:12];
         ex_funct7b5_reg  <= bus.if_instr[30];
         ex_valid_reg     <= load_en && bus.if_valid;
         ex_mem_read_reg  <= load_en && bus.if_valid && mem_read;
         ex_mem_write_reg <= load_en && bus.if_valid && mem_write;
         ex_reg_write_reg <= load_en && bus.if_valid && reg_write;
      end
   end

   assign bus.ex_valid     = ex_valid_reg;
   assign bus.ex_pc        = ex_pc_reg;
   assign bus.ex_rs1_data  = ex_rs1_data_reg;
   assign bus.ex_rs2_data  = ex_rs2_data_reg;
   assign bus.ex_imm       = ex_imm_reg;
   assign bus.ex_rs1       = ex_rs1_reg;
   assign bus.ex_rs2       = ex_rs2_reg;
   assign bus.ex_rd        = ex_rd_reg;
   assign bus.ex_opcode    = ex_opcode_reg;
   assign bus.ex_funct3    = ex_funct3_reg;
   assign bus.ex_funct7b5  = ex_funct7b5_reg;
   assign bus.ex_mem_read  = ex_mem_read_reg;
   assign bus.ex_mem_write = ex_mem_write_reg;
   assign bus.ex_reg_write = ex_reg_write_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode/immediate table plus load-use, WB collision,
// flush, backpressure and reset-mid-stall sequences.
module tb_id_ex_stage;
   logic clk;
   logic rst;
   int   passed;
   int   total;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] e_rs1d;
      logic [31:0] e_rs2d;
      logic [31:0] e_imm;
      logic [4:0]  e_rd;
      logic        e_rw;
      logic        e_mr;
      logic        e_mw;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] rd1, input logic [31:0] rd2);
      bus.if_valid = 1'b1;
      bus.if_instr = instr;
      bus.if_pc    = 32'h0000_0200;
      bus.rf_rd1   = rd1;
      bus.rf_rd2   = rd2;
      #1;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      vecs[0]  = '{32'h00428333, 32'h5,    32'h4,    32'h5,    32'h4,    32'h0,        5'd6,  1'b1, 1'b0, 1'b0};
      vecs[1]  = '{32'hFFF10093, 32'h100,  32'h22,   32'h100,  32'h22,   32'hFFFFFFFF, 5'd1,  1'b1, 1'b0, 1'b0};
      vecs[2]  = '{32'h0082A383, 32'h1000, 32'h33,   32'h1000, 32'h33,   32'h8,        5'd7,  1'b1, 1'b1, 1'b0};
      vecs[3]  = '{32'hFE612E23, 32'h2000, 32'hDEAD, 32'h2000, 32'hDEAD, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{32'hFE000CE3, 32'h55,   32'h66,   32'h0,    32'h0,    32'hFFFFFFF8, 5'd25, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{32'h00001037, 32'h77,   32'h88,   32'h0,    32'h0,    32'h00001000, 5'd0,  1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'hABCDE1B7, 32'h12,   32'h34,   32'h12,   32'h34,   32'hABCDE000, 5'd3,  1'b1, 1'b0, 1'b0};
      vecs[7]  = '{32'hFFDFF0EF, 32'h9,    32'hA,    32'h9,    32'hA,    32'hFFFFFFFC, 5'd1,  1'b1, 1'b0, 1'b0};
      vecs[8]  = '{32'h00008067, 32'h44,   32'h99,   32'h44,   32'h0,    32'h0,        5'd0,  1'b0, 1'b0, 1'b0};
      vecs[9]  = '{32'h80000297, 32'h3,    32'h4,    32'h0,    32'h0,    32'h80000000, 5'd5,  1'b1, 1'b0, 1'b0};
      vecs[10] = '{32'h00209863, 32'h1,    32'h2,    32'h1,    32'h2,    32'h00000010, 5'd16, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'hFFFFFF8B, 32'hAB,   32'hCD,   32'hAB,   32'hCD,   32'h0,        5'd31, 1'b0, 1'b0, 1'b0};

      rst          = 1'b1;
      bus.if_valid = 1'b1;
      bus.if_instr = 32'h00428333;
      bus.if_pc    = 32'h0000_0040;
      bus.rf_rd1   = 32'h5;
      bus.rf_rd2   = 32'h4;
      bus.wb_we    = 1'b0;
      bus.wb_rd    = '0;
      bus.wb_data  = '0;
      bus.ex_ready = 1'b1;
      bus.ex_flush = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_valid", 32'(bus.ex_valid), 32'h0);
      chk("rst_pc", bus.ex_pc, 32'h0);
      chk("rst_rd", 32'(bus.ex_rd), 32'h0);
      chk("rst_rw", 32'(bus.ex_reg_write), 32'h0);
      chk("rst_stall", 32'(bus.id_stall), 32'h0);
      rst = 1'b0;

      // Decode / immediate table, one instruction per cycle
      for (int i = 0; i < 12; i++) begin
         bus.if_valid = 1'b1;
         bus.if_instr = vecs[i].instr;
         bus.if_pc    = 32'h100 + 32'(4 * i);
         bus.rf_rd1   = vecs[i].rd1;
         bus.rf_rd2   = vecs[i].rd2;
         #1;
         chk($sformatf("v%0d_stall", i), 32'(bus.id_stall), 32'h0);
         tick();
         $display("vec %0d instr=%08h imm=%08h rd=%0d rw=%0b", i, vecs[i].instr, bus.ex_imm, bus.ex_rd, bus.ex_reg_write);
         chk($sformatf("v%0d_valid", i), 32'(bus.ex_valid), 32'h1);
         chk($sformatf("v%0d_pc", i), bus.ex_pc, 32'h100 + 32'(4 * i));
         chk($sformatf("v%0d_rs1d", i), bus.ex_rs1_data, vecs[i].e_rs1d);
         chk($sformatf("v%0d_rs2d", i), bus.ex_rs2_data, vecs[i].e_rs2d);
         chk($sformatf("v%0d_imm", i), bus.ex_imm, vecs[i].e_imm);
         chk($sformatf("v%0d_rd", i), 32'(bus.ex_rd), 32'(vecs[i].e_rd));
         chk($sformatf("v%0d_ctrl", i), 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}),
             32'({vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw}));
      end

      // Load-use: lw x7,0(x5) then add x8,x7,x4
      drive(32'h0002A383, 32'h5, 32'h0);
      tick();
      drive(32'h00438433, 32'h70, 32'h4);
      chk("lu_a1", 32'(bus.rf_a1), 32'd7);
      chk("lu_a2", 32'(bus.rf_a2), 32'd4);
      chk("lu_stall1", 32'(bus.id_stall), 32'h1);
      tick();
      $display("load-use bubble valid=%0b stall=%0b", bus.ex_valid, bus.id_stall);
      chk("lu_bubble_valid", 32'(bus.ex_valid), 32'h0);
      chk("lu_bubble_mr", 32'(bus.ex_mem_read), 32'h0);
      chk("lu_stall2", 32'(bus.id_stall), 32'h0);
      tick();
      $display("load-use add valid=%0b rs1=%0d", bus.ex_valid, bus.ex_rs1);
      chk("lu_add_valid", 32'(bus.ex_valid), 32'h1);
      chk("lu_add_rs1", 32'(bus.ex_rs1), 32'd7);
      chk("lu_add_rd", 32'(bus.ex_rd), 32'd8);
      chk("lu_add_rs1d", bus.ex_rs1_data, 32'h70);

      // Same-cycle writeback of x5 while add x6,x5,x4 decodes
      drive(32'h00428333, 32'h5, 32'h4);
      bus.wb_we   = 1'b1;
      bus.wb_rd   = 5'd5;
      bus.wb_data = 32'h11;
      #1;
`ifdef ID_WB_BYPASS_EN
      chk("wb_stall", 32'(bus.id_stall), 32'h0);
      tick();
      bus.wb_we = 1'b0;
      $display("wb bypass rs1d=%08h", bus.ex_rs1_data);
      chk("wb_valid", 32'(bus.ex_valid), 32'h1);
      chk("wb_rs1d", bus.ex_rs1_data, 32'h11);
`else
      chk("wb_stall", 32'(bus.id_stall), 32'h1);
      tick();
      chk("wb_bubble", 32'(bus.ex_valid), 32'h0);
      bus.wb_we  = 1'b0;
      bus.rf_rd1 = 32'h11;
      #1;
      chk("wb_stall2", 32'(bus.id_stall), 32'h0);
      tick();
      $display("wb collision add rs1d=%08h", bus.ex_rs1_data);
      chk("wb_valid", 32'(bus.ex_valid), 32'h1);
      chk("wb_rs1d", bus.ex_rs1_data, 32'h11);
`endif

      // Flush while a load-use hazard is present
      drive(32'h0002A383, 32'h5, 32'h0);
      tick();
      drive(32'h00438433, 32'h70, 32'h4);
      bus.ex_flush = 1'b1;
      #1;
      chk("fl_stall", 32'(bus.id_stall), 32'h0);
      tick();
      bus.ex_flush = 1'b0;
      $display("flush valid=%0b rw=%0b", bus.ex_valid, bus.ex_reg_write);
      chk("fl_valid", 32'(bus.ex_valid), 32'h0);
      chk("fl_rw", 32'(bus.ex_reg_write), 32'h0);

      // EX backpressure for three cycles, flush pulse ignored
      drive(32'hFFF10093, 32'h100, 32'h0);
      tick();
      drive(32'h00500493, 32'h0, 32'h0);
      bus.ex_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         bus.ex_flush = (c == 1);
         #1;
         chk($sformatf("bp%0d_stall", c), 32'(bus.id_stall), 32'h1);
         tick();
         $display("backpressure cycle %0d valid=%0b rd=%0d imm=%08h", c, bus.ex_valid, bus.ex_rd, bus.ex_imm);
         chk($sformatf("bp%0d_valid", c), 32'(bus.ex_valid), 32'h1);
         chk($sformatf("bp%0d_rd", c), 32'(bus.ex_rd), 32'd1);
         chk($sformatf("bp%0d_imm", c), bus.ex_imm, 32'hFFFFFFFF);
      end
      bus.ex_flush = 1'b0;
      bus.ex_ready = 1'b1;
      #1;
      chk("bp_release_stall", 32'(bus.id_stall), 32'h0);
      tick();
      chk("bp_release_rd", 32'(bus.ex_rd), 32'd9);
      chk("bp_release_imm", bus.ex_imm, 32'h5);
      chk("bp_release_valid", 32'(bus.ex_valid), 32'h1);

      // Dead slot in IF/ID
      drive(32'hFFF10093, 32'h100, 32'h0);
      bus.if_valid = 1'b0;
      tick();
      chk("inv_valid", 32'(bus.ex_valid), 32'h0);
      chk("inv_rw", 32'(bus.ex_reg_write), 32'h0);

      // Reset asserted while stalled on a load-use
      drive(32'h0002A383, 32'h5, 32'h0);
      tick();
      drive(32'h00438433, 32'h70, 32'h4);
      chk("rs_stall_pre", 32'(bus.id_stall), 32'h1);
      rst = 1'b1;
      #1;
      chk("rs_stall_rst", 32'(bus.id_stall), 32'h0);
      tick();
      rst = 1'b0;
      #1;
      $display("reset mid-stall valid=%0b stall=%0b", bus.ex_valid, bus.id_stall);
      chk("rs_valid", 32'(bus.ex_valid), 32'h0);
      chk("rs_rd", 32'(bus.ex_rd), 32'h0);
      chk("rs_imm", bus.ex_imm, 32'h0);
      chk("rs_pc", bus.ex_pc, 32'h0);
      chk("rs_rs1d", bus.ex_rs1_data, 32'h0);
      chk("rs_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}), 32'h0);
      chk("rs_stall", 32'(bus.id_stall), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
